// File: rtl/fsqrt_seq.sv
// Sequencer around a fixed-latency fsqrt unit: special-case bypass,
// in-order result FIFO and credit-based input flow control.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake (in_x operand, in_tag dest)
//   sq_x / sq_y            operand to and result from the fsqrt unit
//   out_valid/out_ready    result handshake (out_y, out_tag, out_inv)
//   busy                   any request in flight or buffered
module fsqrt_seq #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int TAGW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     sq_x,
  input  logic [31:0]     sq_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_inv,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DMAX  = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic            v;
    logic [TAGW-1:0] tag;
    logic            sp;
    logic [31:0]     sv;
    logic            inv;
  } pipe_t;

  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            inv;
  } ent_t;

  logic          acc, pop, wr;
  logic [CW-1:0] cnt, occ;
  logic [PW-1:0] wptr, rptr;
  pipe_t         cls;
  pipe_t         pipe [LATENCY];
  pipe_t         tail;
  ent_t          mem [DEPTH];
  ent_t          wdat, head;

  logic          sg;
  logic [7:0]    ex;
  logic [22:0]   mt;
  logic          isz, isnan, ispinf, isneg;

  assign sq_x      = in_x;
  assign in_ready  = (cnt < DMAX) && !rst;
  assign acc       = in_valid && in_ready;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (cnt != '0);

  assign sg     = in_x[31];
  assign ex     = in_x[30:23];
  assign mt     = in_x[22:0];
  assign isz    = (ex == 8'h00);
  assign isnan  = (&ex) && (|mt);
  assign ispinf = !sg && (&ex) && !(|mt);
  assign isneg  = sg && !isz && !isnan;

  always_comb begin
    cls     = '0;
    cls.v   = acc;
    cls.tag = in_tag;
    unique case (1'b1)
      isz: begin
        cls.sp = 1'b1;
        cls.sv = {sg, 31'h0};
      end
      isnan: begin
        cls.sp = 1'b1;
        cls.sv = 32'h7FC0_0000;
      end
      ispinf: begin
        cls.sp = 1'b1;
        cls.sv = 32'h7F80_0000;
      end
      isneg: begin
        cls.sp  = 1'b1;
        cls.sv  = 32'h7FC0_0000;
        cls.inv = 1'b1;
      end
      default: ;
    endcase
  end

  // Fixed-latency shadow of the fsqrt unit; never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i].v <= 1'b0;
    end else begin
      pipe[0] <= cls;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail     = pipe[LATENCY-1];
  assign wr       = tail.v;
  assign wdat.y   = tail.sp ? tail.sv : sq_y;
  assign wdat.tag = tail.tag;
  assign wdat.inv = tail.inv;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  // cnt covers in-flight plus buffered, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wdat;
        wptr      <= inc(wptr);
      end
      if (pop) rptr <= inc(rptr);
      occ <= occ + CW'(wr) - CW'(pop);
      cnt <= cnt + CW'(acc) - CW'(pop);
    end
  end

  assign head    = mem[rptr];
  assign out_y   = out_valid ? head.y   : '0;
  assign out_tag = out_valid ? head.tag : '0;
  assign out_inv = out_valid ? head.inv : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr && occ == DMAX))
        else $error("fsqrt_seq: write into full result fifo");
    end
  end

endmodule

// File: doc/fsqrt_seq.md
FSQRT_SEQ -- requirements
Module: fsqrt_seq

Interface
REQ-001 SHALL have parameter LATENCY, default 4: edges from sq_x sampled by the fsqrt unit to sq_y valid, where 1 means a registered output.
REQ-002 SHALL have parameter DEPTH, default 8: result FIFO entries and total credit limit; legal only if DEPTH >= LATENCY+2.
REQ-003 SHALL have parameter TAGW, default 5: width of the destination tag.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports, name direction width meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when high with in_valid
- in_x  in  32  IEEE-754 single operand
- in_tag  in  TAGW  destination tag
- sq_x  out  32  operand to fsqrt unit
- sq_y  in  32  result from fsqrt unit
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_y  out  32  square-root result
- out_tag  out  TAGW  tag of out_y
- out_inv  out  1  invalid-operation flag for out_y
- busy  out  1  any request in flight or buffered

Function
REQ-006 Accept = in_valid && in_ready at a rising edge of clk.
REQ-007 sq_x SHALL equal in_x combinationally in every cycle.
REQ-008 A LATENCY-deep shift register SHALL carry {valid, tag, special, special_value, inv} for each accepted request, advancing every cycle with no stall.
REQ-009 Special classification at accept; special results SHALL bypass sq_y:
- exp=0, positive sign: result 0x00000000, inv=0
- exp=0, negative sign: result 0x80000000, inv=0
- +inf (0x7F800000): result 0x7F800000, inv=0
- any NaN: result 0x7FC00000, inv=0
- negative with exp!=0, including -inf: result 0x7FC00000, inv=1
- all other operands are normal and take sq_y.
REQ-010 When the shift-register tail is valid at an edge, the block SHALL write {special ? special_value : sq_y, tag, inv} into the FIFO at that edge.
REQ-011 A request accepted at edge t SHALL be written into the FIFO at edge t+LATENCY.
REQ-012 With the FIFO empty and out_ready=1, out_valid SHALL rise in the cycle after edge t+LATENCY, with latency LATENCY+1.
REQ-013 Results SHALL leave in acceptance order, specials included; no reordering.
REQ-014 FIFO pop = out_valid && out_ready; out_y, out_tag and out_inv SHALL show the head entry and hold stable while out_valid && !out_ready.
REQ-015 Credit count = in-flight valid bits + FIFO occupancy, all registered; in_ready = (count < DEPTH) && !rst.
REQ-016 A pop SHALL NOT raise in_ready in the same cycle; the freed credit is visible from the next cycle.
REQ-017 Simultaneous FIFO write and pop in one cycle SHALL both take effect, leaving occupancy unchanged.
REQ-018 A write into an empty FIFO with out_ready=1 SHALL NOT bypass; out_valid follows one cycle later.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; overflow is impossible by the credit rule; a write when the FIFO is full is a design error, flagged by an assertion.
REQ-020 With out_ready held at 1 and in_valid held at 1, the block SHALL accept one request per cycle indefinitely.
REQ-021 busy = (count != 0).

Reset
REQ-022 While rst=1 at an edge, the block SHALL clear all shift-register valid bits, the FIFO pointers and the counts.
REQ-023 Reset values: in_ready=0 during rst, 1 from the first cycle after; out_valid=0, out_y=0, out_tag=0, out_inv=0, busy=0.
REQ-024 Reset mid-operation SHALL discard all in-flight and buffered results; sq_y values arriving after reset SHALL be ignored.

Verification
REQ-025 in_x=0x40800000 (4.0), tag=3, out_ready=1 -> out_y=0x40000000, tag=3, inv=0, out_valid exactly LATENCY+1 cycles after accept.
REQ-026 in_x=0xBF800000 (-1.0) -> out_y=0x7FC00000, inv=1; in_x=0x80000000 -> out_y=0x80000000, inv=0; in_x=0x7F800000 -> 0x7F800000.
REQ-027 Interleaved 0x41100000 (9.0) and 0xC0000000 (-2.0) with tags 0..7 -> outputs 0x40400000 and 0x7FC00000 alternating, tags in order 0..7.
REQ-028 out_ready=0 with in_valid held 1 -> exactly DEPTH accepts, then in_ready=0; raise out_ready -> DEPTH results in order, no loss or duplicates.
REQ-029 Back-to-back random normal operands with out_ready=1 -> one accept per cycle, sustained; every out_y equals the fsqrt model output for its operand.
REQ-030 Accept 3 requests, assert rst for 1 cycle before any result arrives -> no out_valid afterwards, busy=0, in_ready=1 from the cycle after reset.
